// File: rtl/mp_add_seq_64.sv
// Sequential multi-precision adder front end: OP register -> external 64-bit adder -> RES register.
// Latency 2 cycles at full throughput; a stalled RES holds its word and OP buffers one more before in_ready drops.
module mp_add_seq_64 #(
  parameter int MAX_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  output logic             add_cin,
  input  logic [63:0]      add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             err_seq
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_valid;
  logic [63:0]      op_a, op_b;
  logic             op_cin, op_first, op_last;
  logic [IDX_W-1:0] op_idx;
  logic             carry_q;

  logic             advance, accept;
  logic             start, at_max, word_last, frame_err;
  logic [IDX_W-1:0] word_idx;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !op_valid || advance;
  assign accept   = in_valid && in_ready;

  // Framing decode of the word currently offered on the input.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start     = in_first || (state_q == IDLE);
    word_idx  = start ? '0 : idx_q;
    at_max    = (word_idx == IDX_W'(MAX_WORDS - 1));
    word_last = in_last || at_max;
    frame_err = ((state_q == IDLE) && !in_first) ||
                ((state_q == BUSY) && in_first)  ||
                (at_max && !in_last);
    if (accept) begin
      state_d = word_last ? IDLE : BUSY;
      idx_d   = word_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_first <= 1'b0;
      op_last  <= 1'b0;
      op_idx   <= '0;
    end else if (in_ready) begin
      op_valid <= in_valid;
      if (accept) begin
        op_a     <= in_a;
        op_b     <= in_b;
        op_cin   <= in_cin;
        op_first <= start;
        op_last  <= word_last;
        op_idx   <= word_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq <= 1'b0;
    end else if (accept && frame_err) begin
      err_seq <= 1'b1;
    end
  end

  // The carry only ever reaches the next word of the same operand: first words take cin instead.
  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_first ? op_cin : carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      carry_q   <= 1'b0;
    end else if (advance) begin
      if (op_valid) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        out_idx   <= op_idx;
        out_last  <= op_last;
        out_cout  <= op_last & add_cout;
        out_ovf   <= op_last & (op_a[63] == op_b[63]) & (add_sum[63] != op_a[63]);
        carry_q   <= add_cout;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mp_add_seq_64.sv
// Directed bench for mp_add_seq_64 with a behavioural 64-bit adder on the add_* port.
module tb_mp_add_seq_64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b;
  logic        in_cin, in_first, in_last;
  logic [63:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready;
  logic [63:0] out_sum;
  logic [1:0]  out_idx;
  logic        out_last, out_cout, out_ovf, err_seq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] sum;
    logic [1:0]  idx;
    logic        last;
    logic        cout;
    logic        ovf;
    int          cyc;
  } obs_t;

  obs_t oq[$];
  int   icyc[$];
  obs_t mon_o;

  mp_add_seq_64 #(.MAX_WORDS(4), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_first(in_first), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf), .err_seq(err_seq)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        mon_o.sum  = out_sum;
        mon_o.idx  = out_idx;
        mon_o.last = out_last;
        mon_o.cout = out_cout;
        mon_o.ovf  = out_ovf;
        mon_o.cyc  = cyc;
        oq.push_back(mon_o);
      end
      if (in_valid && in_ready) icyc.push_back(cyc);
    end
  end

  task automatic send_word(input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic first, input logic last);
    logic ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 60; k++) begin
      if (oq.size() >= n) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++;
    if (oq.size() != n) begin
      bad++;
      $display("FAIL out_count: got %0d words, required %0d", oq.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_sum !== 64'd0) begin bad++; $display("FAIL rst_out_sum: got %h want 0", out_sum); end
    total++; if (err_seq !== 1'b0) begin bad++; $display("FAIL rst_err_seq: got %b want 0", err_seq); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_carry4;
    oq.delete();
    icyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_word(64'hFFFF_FFFF_FFFF_FFFF, (i == 0) ? 64'd1 : 64'd0, 1'b0, i == 0, i == 3);
    wait_out(4);
    for (int i = 0; i < oq.size() && i < 4; i++) begin
      total++; if (oq[i].sum !== 64'd0) begin bad++; $display("FAIL c4_sum[%0d]: got %h want 0", i, oq[i].sum); end
      total++; if (oq[i].idx !== 2'(i)) begin bad++; $display("FAIL c4_idx[%0d]: got %0d want %0d", i, oq[i].idx, i); end
      total++; if (oq[i].last !== (i == 3)) begin bad++; $display("FAIL c4_last[%0d]: got %b want %b", i, oq[i].last, i == 3); end
      total++; if (oq[i].cout !== (i == 3)) begin bad++; $display("FAIL c4_cout[%0d]: got %b want %b", i, oq[i].cout, i == 3); end
    end
    if (oq.size() == 4 && icyc.size() > 0) begin
      total++; if (oq[0].cyc - icyc[0] != 2) begin bad++; $display("FAIL c4_latency: got %0d want 2", oq[0].cyc - icyc[0]); end
      total++; if (oq[3].cyc - oq[0].cyc != 3) begin bad++; $display("FAIL c4_throughput: got %0d want 3", oq[3].cyc - oq[0].cyc); end
    end
  endtask

  task automatic test_single;
    oq.delete();
    out_ready = 1'b1;
    send_word(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1);
    wait_out(1);
    if (oq.size() > 0) begin
      total++; if (oq[0].sum !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL single_sum: got %h want 8000000000000000", oq[0].sum); end
      total++; if (oq[0].ovf !== 1'b1) begin bad++; $display("FAIL single_ovf: got %b want 1", oq[0].ovf); end
      total++; if (oq[0].cout !== 1'b0) begin bad++; $display("FAIL single_cout: got %b want 0", oq[0].cout); end
      total++; if (oq[0].last !== 1'b1 || oq[0].idx !== 2'd0) begin bad++; $display("FAIL single_last_idx: got %b/%0d want 1/0", oq[0].last, oq[0].idx); end
    end
    total++; if (err_seq !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err_seq); end
  endtask

  task automatic test_backpressure;
    logic [63:0] wa [4];
    logic [63:0] wb [4];
    logic [63:0] es [4];
    wa = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0005, 64'h1234_0000_0000_0000};
    wb = '{64'h0000_0000_0000_0002, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 64'h1111_0000_0000_0000};
    es = '{64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h2345_0000_0000_0001};
    oq.delete();
    out_ready = 1'b0;
    send_word(wa[0], wb[0], 1'b1, 1'b1, 1'b0);
    send_word(wa[1], wb[1], 1'b1, 1'b0, 1'b0);
    in_a = wa[2]; in_b = wb[2]; in_cin = 1'b0; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      total++; if (out_valid !== 1'b1 || out_sum !== es[0] || out_idx !== 2'd0) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b sum=%h idx=%0d want v=1 sum=%h idx=0", c, out_valid, out_sum, out_idx, es[0]);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_word(wa[2], wb[2], 1'b0, 1'b0, 1'b0);
    send_word(wa[3], wb[3], 1'b0, 1'b0, 1'b1);
    wait_out(4);
    for (int i = 0; i < oq.size() && i < 4; i++) begin
      total++; if (oq[i].sum !== es[i] || oq[i].idx !== 2'(i)) begin
        bad++; $display("FAIL bp_word[%0d]: got sum=%h idx=%0d want sum=%h idx=%0d", i, oq[i].sum, oq[i].idx, es[i], i);
      end
      total++; if (oq[i].last !== (i == 3) || oq[i].cout !== 1'b0 || oq[i].ovf !== 1'b0) begin
        bad++; $display("FAIL bp_flags[%0d]: got last=%b cout=%b ovf=%b want last=%b cout=0 ovf=0", i, oq[i].last, oq[i].cout, oq[i].ovf, i == 3);
      end
    end
  endtask

  task automatic test_framing;
    logic [63:0] es [3];
    logic [1:0]  ei [3];
    es = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_000B};
    ei = '{2'd0, 2'd0, 2'd1};
    oq.delete();
    out_ready = 1'b1;
    total++; if (err_seq !== 1'b0) begin bad++; $display("FAIL frm_err_pre: got %b want 0", err_seq); end
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b0);
    send_word(64'd5, 64'd6, 1'b1, 1'b0, 1'b1);
    wait_out(3);
    for (int i = 0; i < oq.size() && i < 3; i++) begin
      total++; if (oq[i].sum !== es[i] || oq[i].idx !== ei[i] || oq[i].last !== (i == 2)) begin
        bad++; $display("FAIL frm_word[%0d]: got sum=%h idx=%0d last=%b want sum=%h idx=%0d last=%b",
                        i, oq[i].sum, oq[i].idx, oq[i].last, es[i], ei[i], i == 2);
      end
    end
    total++; if (err_seq !== 1'b1) begin bad++; $display("FAIL frm_err: got %b want 1", err_seq); end
  endtask

  task automatic test_max_words;
    oq.delete();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (err_seq !== 1'b0) begin bad++; $display("FAIL max_err_cleared: got %b want 0", err_seq); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_word(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, i == 0, i == 0, 1'b0);
    total++; if (err_seq !== 1'b1) begin bad++; $display("FAIL max_err: got %b want 1", err_seq); end
    send_word(64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    wait_out(5);
    for (int i = 0; i < oq.size() && i < 5; i++) begin
      total++; if (oq[i].sum !== 64'd0 || oq[i].idx !== 2'(i % 4)) begin
        bad++; $display("FAIL max_word[%0d]: got sum=%h idx=%0d want sum=0 idx=%0d", i, oq[i].sum, oq[i].idx, i % 4);
      end
      total++; if (oq[i].last !== (i >= 3) || oq[i].cout !== (i == 3)) begin
        bad++; $display("FAIL max_flags[%0d]: got last=%b cout=%b want last=%b cout=%b", i, oq[i].last, oq[i].cout, i >= 3, i == 3);
      end
    end
  endtask

  task automatic test_reset_mid;
    oq.delete();
    out_ready = 1'b1;
    send_word(64'd3, 64'd4, 1'b0, 1'b1, 1'b0);
    send_word(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_sum !== 64'd7) begin
      bad++; $display("FAIL rm_pre: got v=%b sum=%h want v=1 sum=7", out_valid, out_sum);
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
      bad++; $display("FAIL rm_clear: got v=%b sum=%h idx=%0d last=%b want all 0", out_valid, out_sum, out_idx, out_last);
    end
    total++; if (in_ready !== 1'b1 || err_seq !== 1'b0) begin
      bad++; $display("FAIL rm_ready_err: got rdy=%b err=%b want rdy=1 err=0", in_ready, err_seq);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (oq.size() != 0) begin bad++; $display("FAIL rm_no_partial: got %0d words want 0", oq.size()); end
    @(posedge clk);
    #1;
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
    send_word(64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
    wait_out(2);
    if (oq.size() == 2) begin
      total++; if (oq[0].sum !== 64'd0 || oq[0].idx !== 2'd0 || oq[0].last !== 1'b0) begin
        bad++; $display("FAIL rm_w0: got sum=%h idx=%0d last=%b want 0/0/0", oq[0].sum, oq[0].idx, oq[0].last);
      end
      total++; if (oq[1].sum !== 64'd4 || oq[1].idx !== 2'd1 || oq[1].last !== 1'b1 || oq[1].cout !== 1'b0) begin
        bad++; $display("FAIL rm_w1: got sum=%h idx=%0d last=%b cout=%b want 4/1/1/0", oq[1].sum, oq[1].idx, oq[1].last, oq[1].cout);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_carry4();
    test_single();
    test_backpressure();
    test_framing();
    test_max_words();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mp_add_seq_64.md
MP_ADD_SEQ_64 -- requirements
Module: mp_add_seq_64

Interface
REQ-001 SHALL provide parameter MAX_WORDS, default 4: maximum 64-bit words per multi-precision operand (2..16).
REQ-002 SHALL provide parameter IDX_W, default 2: width of the word index, equal to clog2(MAX_WORDS).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand word pair offered.
- in_ready  out  1  word pair accepted when in_valid and in_ready are both high.
- in_a  in  64  operand A word, least significant word first.
- in_b  in  64  operand B word.
- in_cin  in  1  carry-in, used only on the first word.
- in_first  in  1  marks the least significant word.
- in_last  in  1  marks the most significant word.
- add_a  out  64  to the 64-bit prefix adder.
- add_b  out  64  to the 64-bit prefix adder.
- add_cin  out  1  to the 64-bit prefix adder.
- add_sum  in  64  from the adder; combinational, same cycle.
- add_cout  in  1  from the adder; combinational, same cycle.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts.
- out_sum  out  64  result word.
- out_idx  out  IDX_W  word index within the operand.
- out_last  out  1  most significant result word.
- out_cout  out  1  final carry-out; meaningful when out_last is high, 0 otherwise.
- out_ovf  out  1  signed overflow; meaningful when out_last is high, 0 otherwise.
- err_seq  out  1  sticky framing error.

Function
REQ-005 SHALL be a 2-stage pipeline: operand register (OP) -> external adder, combinational -> result register (RES).
REQ-006 SHALL drive add_a and add_b from the OP registers, not from the inputs.
REQ-007 SHALL drive add_cin = OP.first ? OP.cin : carry_q.
REQ-008 SHALL define advance = !out_valid | out_ready, and in_ready = !op_valid | advance.
REQ-009 On advance with op_valid, SHALL load RES from the adder outputs and set out_valid.
REQ-010 On advance with !op_valid, SHALL clear out_valid.
REQ-011 On the same advance as REQ-009, SHALL load carry_q with add_cout.
REQ-012 SHALL give a latency of 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-013 SHALL sustain a throughput of 1 word per cycle.
REQ-014 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-015 SHALL implement FSM IDLE/BUSY:
- IDLE -> BUSY on an accepted word with in_first=1 and in_last=0.
- BUSY -> IDLE on an accepted word with in_last=1.
- A single-word operand (first and last both high) stays in IDLE.
REQ-016 SHALL set the word index to 0 on a first word and increment it on each later accepted word.
REQ-017 SHALL register the index with the word and present it as out_idx.
REQ-018 SHALL compute out_ovf = (a[63]==b[63]) & (sum[63]!=a[63]) for the last word, where a and b are the OP-stage MSBs.
REQ-019 Boundary: word accepted in IDLE with in_first=0 -> treat as a first word (cin=in_cin) and set err_seq.
REQ-020 Boundary: in_first=1 while BUSY -> start a new operand (index 0, cin=in_cin) and set err_seq.
REQ-021 Boundary: word at index MAX_WORDS-1 with in_last=0 -> force out_last=1, return to IDLE, set err_seq.
REQ-022 SHALL generate the carry for a word only from the immediately preceding word of the same operand, never across operands.
REQ-023 SHALL keep err_seq sticky; only reset clears it.

Reset
REQ-024 On rst_n low, SHALL immediately clear op_valid, out_valid, out_sum, out_idx, out_last, out_cout, out_ovf, err_seq and carry_q, and set the FSM to IDLE.
REQ-025 SHALL drive in_ready=1 during and after reset.
REQ-026 SHALL discard an operand interrupted by reset; no partial words SHALL be emitted after reset release.

Verification
REQ-027 4-word add, A=all 1s, B=1, cin=0, out_ready=1 -> sums 0,0,0,0; out_idx 0..3; out_last only on idx 3; out_cout=1; first output 2 cycles after the first handshake.
REQ-028 Single word (first and last), A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum 0x8000_0000_0000_0000, out_ovf=1, out_cout=0.
REQ-029 Backpressure: out_ready low for 3 cycles mid-operand -> in_ready drops after 2 buffered words, out_* held, no word lost or duplicated, carries correct.
REQ-030 Framing errors: non-first word in IDLE, then in_first while BUSY -> err_seq=1, both operands restart their carry from in_cin.
REQ-031 rst_n asserted after 2 of 4 words accepted -> outputs 0 in the same cycle; a new 2-word operand after release gives the correct sum and idx 0,1.
